// File: rtl/outlier_pkg.sv
// Shared types and helpers for the outlier collector.
// Holds the frame state enum, default pointer width and a prefix-count function.
package outlier_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DRAIN,
      DONE
   } state_t;

   localparam int DEF_DEPTH = 1024;
   localparam int PTR_W     = $clog2(DEF_DEPTH) + 1;
   localparam int MAX_CORES = 8;

   // Number of set bits in mask[upto-1:0]; upto=MAX_CORES gives popcount.
   function automatic logic [3:0] prefix_count(
      input logic [MAX_CORES-1:0] mask,
      input int                   upto
   );
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < MAX_CORES; i++) begin
         if (i < upto && mask[i]) c = c + 4'd1;
      end
      return c;
   endfunction

endpackage

// File: rtl/outlier_compactor.sv
// Combinational mask-to-index compactor: packs point_pos+i for each set mask bit.
// Ports: point_pos, core_outlier in; idx (packed, LSB-first order), count out.
module outlier_compactor
   import outlier_pkg::*;
#(
   parameter int CORE_NUMBER = 2,
   parameter int IDX_W       = 16,
   parameter int CW          = 2
) (
   input  logic [IDX_W-1:0]                   point_pos,
   input  logic [CORE_NUMBER-1:0]             core_outlier,
   output logic [CORE_NUMBER-1:0][IDX_W-1:0]  idx,
   output logic [CW-1:0]                      count
);

   logic [MAX_CORES-1:0] m8;

   always_comb begin
      m8 = '0;
      m8[CORE_NUMBER-1:0] = core_outlier;
      idx = '0;
      // Slot k takes the core whose set bit has exactly k set bits below it.
      for (int k = 0; k < CORE_NUMBER; k++) begin
         for (int i = 0; i < CORE_NUMBER; i++) begin
            if (core_outlier[i] && prefix_count(m8, i) == 4'(k)) begin
               idx[k] = point_pos + IDX_W'(i);
            end
         end
      end
      count = CW'(prefix_count(m8, MAX_CORES));
   end

endmodule

// File: rtl/outlier_collector.sv
// Multi-write compaction FIFO collecting outlier indices from parallel filter cores.
// Ports: clock, reset(n), start, in_valid/in_ready, point_pos, core_outlier, frame_end,
//        read_fifo, outlier_pos, empty, done, overflow; with OUTLIER_STATS_EN also
//        outlier_count and max_occupancy.
module outlier_collector
   import outlier_pkg::*;
#(
   parameter int CORE_NUMBER = 2,
   parameter int IDX_W       = 16,
   parameter int DEPTH       = 1024
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IDX_W-1:0]       point_pos,
   input  logic [CORE_NUMBER-1:0] core_outlier,
   input  logic                   frame_end,
   input  logic                   read_fifo,
   output logic [IDX_W-1:0]       outlier_pos,
   output logic                   empty,
   output logic                   done,
   output logic                   overflow
`ifdef OUTLIER_STATS_EN
  ,output logic [IDX_W:0]            outlier_count,
   output logic [$clog2(DEPTH):0]    max_occupancy
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(CORE_NUMBER + 1);

   state_t state, state_n;

   logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
   logic [PW-1:0] occ, occ_n;
   logic          in_ready_q, empty_q, overflow_q;
   logic          ready_n;
   logic [IDX_W-1:0] head_q;
   logic [IDX_W-1:0] mem [DEPTH];

   logic [CORE_NUMBER-1:0][IDX_W-1:0] cidx;
   logic [CW-1:0] cnt;
   logic          accept, pop, blocked, ptr_eq;

   outlier_compactor #(
      .CORE_NUMBER (CORE_NUMBER),
      .IDX_W       (IDX_W),
      .CW          (CW)
   ) u_compactor (
      .point_pos    (point_pos),
      .core_outlier (core_outlier),
      .idx          (cidx),
      .count        (cnt)
   );

   // start flushes the buffer, so a beat in the same cycle is dropped.
   assign accept   = state == COLLECT && in_valid && in_ready_q && !start;
   assign blocked  = state == COLLECT && in_valid && !in_ready_q
                     && |core_outlier && !start;
   assign pop      = read_fifo && !empty_q;
   assign rd_ptr_n = rd_ptr + PW'(pop);
   assign occ      = wr_ptr - rd_ptr;
   assign occ_n    = occ + (accept ? PW'(cnt) : '0) - PW'(pop);
   assign ptr_eq   = wr_ptr == rd_ptr;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = COLLECT;
         COLLECT: begin
            if (start)          state_n = COLLECT;
            else if (frame_end) state_n = DRAIN;
         end
         DRAIN: begin
            if (start)                  state_n = COLLECT;
            else if (empty_q && ptr_eq) state_n = DONE;
         end
         DONE:    if (start) state_n = COLLECT;
         default: state_n = IDLE;
      endcase
   end

   // Ready for next cycle from post-update occupancy, so a full beat always fits.
   always_comb begin
      ready_n = 1'b0;
      if (state_n == COLLECT) begin
         if (start) ready_n = 1'b1;
         else       ready_n = (PW'(DEPTH) - occ_n) >= PW'(CORE_NUMBER);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         in_ready_q <= 1'b0;
         empty_q    <= 1'b1;
         head_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state      <= state_n;
         in_ready_q <= ready_n;
         if (start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
         end else begin
            if (accept)  wr_ptr <= wr_ptr + PW'(cnt);
            if (blocked) overflow_q <= 1'b1;
            rd_ptr <= rd_ptr_n;
            // Head uses the pre-edge wr_ptr: new entries show one edge later.
            if (wr_ptr != rd_ptr_n) begin
               head_q  <= mem[rd_ptr_n[AW-1:0]];
               empty_q <= 1'b0;
            end else begin
               empty_q <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         for (int k = 0; k < CORE_NUMBER; k++) begin
            if (k < int'(cnt)) begin
               mem[wr_ptr[AW-1:0] + AW'(k)] <= cidx[k];
            end
         end
      end
   end

`ifdef OUTLIER_STATS_EN
   logic [IDX_W+1:0] cnt_sum;

   assign cnt_sum = {1'b0, outlier_count} + (IDX_W+2)'(cnt);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outlier_count <= '0;
         max_occupancy <= '0;
      end else if (start) begin
         outlier_count <= '0;
         max_occupancy <= '0;
      end else begin
         if (accept) begin
            if (cnt_sum[IDX_W+1]) outlier_count <= '1;
            else                  outlier_count <= cnt_sum[IDX_W:0];
         end
         if (occ_n > max_occupancy) max_occupancy <= occ_n;
      end
   end
`endif

   assign in_ready    = in_ready_q;
   assign outlier_pos = head_q;
   assign empty       = empty_q;
   assign done        = state == DONE;
   assign overflow    = overflow_q;

endmodule
